// File: rtl/mult_accum.sv
// Sums LEN consecutive multiplier products (one per rising edge of finish) and
// presents each completed sum on a valid/ready port with sticky overflow/overrun.
//
// state | meaning
// ACC   | no result held; collecting products
// HOLD  | acc_out valid, waiting for acc_ready; next group keeps collecting
module mult_accum #(
  parameter int N   = 32,
  parameter int G   = 8,
  parameter int LEN = 4,
  localparam int W  = 2*N + G,
  localparam int CW = $clog2(LEN + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            finish,
  input  logic [2*N-1:0]  product,
  output logic [W-1:0]    acc_out,
  output logic            acc_valid,
  input  logic            acc_ready,
  output logic [CW-1:0]   count,
  output logic            overflow,
  output logic            overrun
);

  typedef enum logic {ACC, HOLD} state_t;

  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  state_t       state;
  logic         finish_d;
  logic [W-1:0] acc;
  logic [W:0]   sum;
  logic         ev;
  logic         last;

  assign ev   = finish & ~finish_d;
  assign sum  = {1'b0, acc} + {{(G+1){1'b0}}, product};
  assign last = (count == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state     <= ACC;
      finish_d  <= 1'b1;
      acc       <= '0;
      count     <= '0;
      acc_out   <= '0;
      acc_valid <= 1'b0;
      overflow  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      finish_d <= finish;
      case (state)
        ACC: begin
          if (ev) begin
            if (sum[W]) overflow <= 1'b1;
            if (!last) begin
              acc   <= sum[W-1:0];
              count <= count + CW'(1);
            end else begin
              acc_out   <= sum[W-1:0];
              acc_valid <= 1'b1;
              acc       <= '0;
              count     <= '0;
              state     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (acc_ready) begin
            acc_valid <= 1'b0;
            state     <= ACC;
          end
          if (ev) begin
            if (!last) begin
              if (sum[W]) overflow <= 1'b1;
              acc   <= sum[W-1:0];
              count <= count + CW'(1);
            end else if (acc_ready) begin
              // Result accepted and replaced on the same edge.
              if (sum[W]) overflow <= 1'b1;
              acc_out   <= sum[W-1:0];
              acc_valid <= 1'b1;
              acc       <= '0;
              count     <= '0;
              state     <= HOLD;
            end else begin
              overrun <= 1'b1;
            end
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule
